// File: rtl/lamp_sequencer_if.sv
// Lamp-bar bundle: switch input toward the sequencer and lamp/status outputs back.
// master = switch/board side, slave = lamp_sequencer.
interface lamp_sequencer_if;
  localparam int unsigned N_LAMPS = 16;
  localparam int unsigned CNT_W   = 5;

  logic               flick;
  logic [N_LAMPS-1:0] lamps;
  logic [CNT_W-1:0]   count;
  logic               increase;
  logic               busy;

  modport master (output flick, input lamps, count, increase, busy);
  modport slave  (input flick, output lamps, count, increase, busy);
endinterface

// File: rtl/lamp_sequencer.sv
// 16-lamp fill/drain sequencer: 0->16->5->10->0, one step per TICK_DIV cycles.
// Optional restart-during-drain feature enabled by defining LAMP_SEQ_KICKBACK_EN.
module lamp_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned N_LAMPS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  lamp_sequencer_if.slave   bus
);
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_A   = 3'd1,
    DOWN_A = 3'd2,
    UP_B   = 3'd3,
    DOWN_B = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count_r, count_nxt;
  logic [PRE_W-1:0]   pre, pre_nxt;
  logic               flick_q;
  logic               flick_edge;
  logic               step;
  logic               kick;
  logic [N_LAMPS-1:0] lamps_c;

  assign flick_edge = bus.flick & ~flick_q;
  assign step       = (pre == PRE_W'(TICK_DIV - 1));

`ifdef LAMP_SEQ_KICKBACK_EN
  assign kick = flick_edge;
`else
  assign kick = 1'b0;
`endif

  // flick_q resets high so a switch held on through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_r <= CNT_W'(0);
      pre     <= PRE_W'(0);
      flick_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      count_r <= count_nxt;
      pre     <= pre_nxt;
      flick_q <= bus.flick;
    end
  end

  // Next-state, count and prescaler; boundaries are checked on the new count
  always_comb begin
    state_nxt = state;
    count_nxt = count_r;
    pre_nxt   = step ? PRE_W'(0) : pre + PRE_W'(1);
    unique case (state)
      IDLE: begin
        pre_nxt   = PRE_W'(0);
        count_nxt = CNT_W'(0);
        if (flick_edge) state_nxt = UP_A;
      end
      UP_A: begin
        if (step) begin
          if (count_r >= CNT_W'(N_LAMPS)) begin
            // already full after a kickback at the top: turn straight back down
            count_nxt = count_r - CNT_W'(1);
            state_nxt = DOWN_A;
          end else begin
            count_nxt = count_r + CNT_W'(1);
            if (count_nxt == CNT_W'(N_LAMPS)) state_nxt = DOWN_A;
          end
        end
      end
      DOWN_A: begin
        if (kick) begin
          state_nxt = UP_A;
          pre_nxt   = PRE_W'(0);
        end else if (step) begin
          count_nxt = count_r - CNT_W'(1);
          if (count_nxt == CNT_W'(5)) state_nxt = UP_B;
        end
      end
      UP_B: begin
        if (step) begin
          count_nxt = count_r + CNT_W'(1);
          if (count_nxt == CNT_W'(10)) state_nxt = DOWN_B;
        end
      end
      DOWN_B: begin
        if (kick) begin
          state_nxt = UP_A;
          pre_nxt   = PRE_W'(0);
        end else if (step) begin
          count_nxt = count_r - CNT_W'(1);
          if (count_nxt == CNT_W'(0)) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = CNT_W'(0);
        pre_nxt   = PRE_W'(0);
      end
    endcase
  end

  // Thermometer decode of the registered count
  always_comb begin
    lamps_c = '0;
    for (int i = 0; i < int'(N_LAMPS); i++) begin
      lamps_c[i] = (CNT_W'(i) < count_r);
    end
  end

  assign bus.lamps    = lamps_c;
  assign bus.count    = count_r;
  assign bus.increase = (state == UP_A) || (state == UP_B);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_lamp_sequencer.sv
// Bench for lamp_sequencer: segment-level reference model checked every cycle,
// plus directed cases with hand-computed expectations (TICK_DIV = 4).
module tb_lamp_sequencer;
  localparam int unsigned TICK_DIV = 4;

`ifdef LAMP_SEQ_KICKBACK_EN
  localparam bit KICK = 1'b1;
`else
  localparam bit KICK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lamp_sequencer_if bus();

  lamp_sequencer #(.TICK_DIV(TICK_DIV), .N_LAMPS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequence is four segments, each walking toward a target
  int  seg_target [4] = '{16, 5, 10, 0};
  int  seg_dir    [4] = '{1, -1, 1, -1};
  int  m_cnt   = 0;
  int  m_seg   = 0;
  int  m_timer = 0;
  bit  m_busy  = 1'b0;
  bit  m_fq    = 1'b1;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    bit e;
    e    = bus.flick && !m_fq;
    m_fq = bus.flick;
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_seg   = 0;
      m_timer = 0;
      m_fq    = 1'b1;
    end else if (!m_busy) begin
      if (e) begin
        m_busy  = 1'b1;
        m_seg   = 0;
        m_timer = TICK_DIV;
      end
    end else if (KICK && e && (seg_dir[m_seg] < 0)) begin
      m_seg   = 0;
      m_timer = TICK_DIV;
    end else begin
      m_timer = m_timer - 1;
      if (m_timer == 0) begin
        m_timer = TICK_DIV;
        if (m_seg == 0 && m_cnt >= 16) begin
          m_cnt = m_cnt - 1;
          m_seg = 1;
        end else begin
          m_cnt = m_cnt + seg_dir[m_seg];
          if (m_cnt == seg_target[m_seg]) begin
            if (m_seg == 3) m_busy = 1'b0;
            else            m_seg  = m_seg + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count",    int'(bus.count),    m_cnt);
      chk("model_lamps",    int'(bus.lamps),    int'((32'd1 << m_cnt) - 32'd1));
      chk("model_increase", int'(bus.increase), int'(m_busy && seg_dir[m_seg] > 0));
      chk("model_busy",     int'(bus.busy),     int'(m_busy));
    end
  end

  task automatic step_to(input int t);
    while (cur < t) begin
      @(posedge clk);
      cur++;
      #1;
    end
  endtask

  // Lower flick for one edge, then raise it so edge k is the next clock edge (cur = 0)
  task automatic start_seq();
    bus.flick = 1'b0;
    @(posedge clk);
    #1;
    bus.flick = 1'b1;
    cur = -1;
    step_to(0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_wait", int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.flick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  int'(bus.busy),  0);
    chk("reset_lamps", int'(bus.lamps), 0);
    rst = 1'b0;

    // Case 1: flick held high through reset release does not start
    repeat (100) @(posedge clk);
    #1;
    chk("held_busy",  int'(bus.busy),  0);
    chk("held_lamps", int'(bus.lamps), 0);

    // Case 2: full sequence
    start_seq();
    chk("c2_busy_k", int'(bus.busy), 1);
    chk("c2_count_k", int'(bus.count), 0);
    step_to(1);  bus.flick = 1'b0;
    step_to(3);  chk("c2_count_k3", int'(bus.count), 0);
    step_to(4);  chk("c2_count_k4", int'(bus.count), 1);
    step_to(64);
    chk("c2_count_k64", int'(bus.count), 16);
    chk("c2_lamps_k64", int'(bus.lamps), 32'hFFFF);
    chk("c2_inc_k64",   int'(bus.increase), 0);
    step_to(108);
    chk("c2_count_k108", int'(bus.count), 5);
    chk("c2_lamps_k108", int'(bus.lamps), 32'h001F);
    chk("c2_inc_k108",   int'(bus.increase), 1);
    step_to(128);
    chk("c2_count_k128", int'(bus.count), 10);
    chk("c2_lamps_k128", int'(bus.lamps), 32'h03FF);
    step_to(167); chk("c2_busy_k167", int'(bus.busy), 1);
    step_to(168);
    chk("c2_count_k168", int'(bus.count), 0);
    chk("c2_busy_k168",  int'(bus.busy), 0);

    // Case 3 / 5: flick edge sampled at k+81 while draining at count 12
    start_seq();
    step_to(1);  bus.flick = 1'b0;
    step_to(80); bus.flick = 1'b1;
    step_to(81);
    if (KICK) begin
      chk("c3_inc_k81",   int'(bus.increase), 1);
      chk("c3_count_k81", int'(bus.count), 12);
      step_to(85); chk("c3_count_k85", int'(bus.count), 13);
      step_to(97);
      chk("c3_count_k97", int'(bus.count), 16);
      chk("c3_inc_k97",   int'(bus.increase), 0);
      wait_idle();
    end else begin
      chk("c5_inc_k81",   int'(bus.increase), 0);
      chk("c5_count_k81", int'(bus.count), 12);
      step_to(108); chk("c5_count_k108", int'(bus.count), 5);
      step_to(167); chk("c5_busy_k167", int'(bus.busy), 1);
      step_to(168); chk("c5_busy_k168", int'(bus.busy), 0);
    end

    // Case 4: kickback coinciding with the step at k+68
    if (KICK) begin
      start_seq();
      step_to(1);  bus.flick = 1'b0;
      step_to(67); bus.flick = 1'b1;
      step_to(68);
      chk("c4_count_k68", int'(bus.count), 16);
      chk("c4_inc_k68",   int'(bus.increase), 1);
      step_to(72);
      chk("c4_count_k72", int'(bus.count), 15);
      chk("c4_inc_k72",   int'(bus.increase), 0);
      wait_idle();
    end

    // Case 6: reset mid-sequence, then restart
    start_seq();
    step_to(89); rst = 1'b1;
    step_to(90);
    chk("c6_count_rst", int'(bus.count), 0);
    chk("c6_lamps_rst", int'(bus.lamps), 0);
    chk("c6_inc_rst",   int'(bus.increase), 0);
    chk("c6_busy_rst",  int'(bus.busy), 0);
    rst       = 1'b0;
    bus.flick = 1'b0;
    step_to(92); bus.flick = 1'b1;
    step_to(93);
    chk("c6_busy_k93",  int'(bus.busy), 1);
    step_to(96); chk("c6_count_k96", int'(bus.count), 0);
    step_to(97); chk("c6_count_k97", int'(bus.count), 1);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
